// File: rtl/alu_packet_ctrl.sv
// Packet sequencer: parses uart_rx bytes into a header plus 32-bit payload words,
// folds the words through an external ALU and returns the result (or echoes the payload) to uart_tx.
module alu_packet_ctrl #(
   parameter logic [7:0] ECHO_OP = 8'hEC,
   parameter int         LEN_W   = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic [7:0]  alu_op_o,
   output logic [31:0] alu_a_o,
   output logic [31:0] alu_b_o,
   output logic        alu_start_o,
   input  logic        alu_done_i,
   input  logic [31:0] alu_result_i,
   output logic        busy_o,
   output logic        err_o
);

   typedef enum logic [3:0] {
      HDR_OP, HDR_RSV, DRAIN_HDR, HDR_LEN_LO, HDR_LEN_HI,
      PAY, ALU_START, ALU_WAIT, TX_RESP, ECHO, DRAIN
   } state_t;

   state_t            state;
   logic [7:0]        len_lo;
   logic [LEN_W-1:0]  rx_cnt;
   logic [LEN_W-1:0]  tx_cnt;
   logic [31:0]       word;
   logic [31:0]       acc;
   logic [1:0]        byte_idx;
   logic [1:0]        tx_idx;
   logic              first_word;

   logic              rx_fire;
   logic              tx_fire;
   logic [LEN_W-1:0]  pkt_len;
   logic [LEN_W-1:0]  pay_len;
   logic [31:0]       word_full;
   logic [7:0]        tx_byte;

   assign rx_fire   = s_axis_tvalid & s_axis_tready;
   assign tx_fire   = m_axis_tvalid & m_axis_tready;
   assign pkt_len   = LEN_W'({s_axis_tdata, len_lo});
   assign pay_len   = pkt_len - LEN_W'(4);
   assign word_full = {word[23:0], s_axis_tdata};
   // ~tx_idx == 3 - tx_idx, so the accumulator leaves MSB first
   assign tx_byte   = 8'(acc >> {~tx_idx, 3'b000});
   assign busy_o    = (state != HDR_OP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= HDR_OP;
         s_axis_tready <= 1'b1;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         alu_op_o      <= '0;
         alu_a_o       <= '0;
         alu_b_o       <= '0;
         alu_start_o   <= 1'b0;
         err_o         <= 1'b0;
         len_lo        <= '0;
         rx_cnt        <= '0;
         tx_cnt        <= '0;
         word          <= '0;
         acc           <= '0;
         byte_idx      <= '0;
         tx_idx        <= '0;
         first_word    <= 1'b0;
      end else begin
         alu_start_o <= 1'b0;
         err_o       <= 1'b0;
         case (state)
            HDR_OP: if (rx_fire) begin
               alu_op_o <= s_axis_tdata;
               state    <= HDR_RSV;
            end
            HDR_RSV: if (rx_fire) begin
               if (s_axis_tdata != 8'h00) begin
                  err_o  <= 1'b1;
                  rx_cnt <= LEN_W'(2);
                  state  <= DRAIN_HDR;
               end else begin
                  state <= HDR_LEN_LO;
               end
            end
            HDR_LEN_LO: if (rx_fire) begin
               len_lo <= s_axis_tdata;
               state  <= HDR_LEN_HI;
            end
            HDR_LEN_HI: if (rx_fire) begin
               rx_cnt <= pay_len;
               tx_cnt <= pay_len;
               if (pkt_len < LEN_W'(4)) begin
                  err_o <= 1'b1;
                  state <= HDR_OP;
               end else if (alu_op_o == ECHO_OP) begin
                  state <= (pay_len == '0) ? HDR_OP : ECHO;
               end else if (pay_len < LEN_W'(4) || pay_len[1:0] != 2'b00) begin
                  err_o <= 1'b1;
                  state <= (pay_len == '0) ? HDR_OP : DRAIN;
               end else begin
                  byte_idx   <= '0;
                  first_word <= 1'b1;
                  state      <= PAY;
               end
            end
            PAY: if (rx_fire) begin
               word     <= word_full;
               rx_cnt   <= rx_cnt - LEN_W'(1);
               byte_idx <= byte_idx + 2'd1;
               if (byte_idx == 2'd3) begin
                  if (first_word) begin
                     acc        <= word_full;
                     first_word <= 1'b0;
                     if (rx_cnt == LEN_W'(1)) begin
                        s_axis_tready <= 1'b0;
                        tx_idx        <= '0;
                        state         <= TX_RESP;
                     end
                  end else begin
                     alu_a_o       <= acc;
                     alu_b_o       <= word_full;
                     s_axis_tready <= 1'b0;
                     state         <= ALU_START;
                  end
               end
            end
            ALU_START: begin
               alu_start_o <= 1'b1;
               state       <= ALU_WAIT;
            end
            ALU_WAIT: if (alu_done_i) begin
               acc <= alu_result_i;
               if (rx_cnt == '0) begin
                  tx_idx <= '0;
                  state  <= TX_RESP;
               end else begin
                  s_axis_tready <= 1'b1;
                  state         <= PAY;
               end
            end
            TX_RESP: begin
               if (!m_axis_tvalid) begin
                  m_axis_tdata  <= tx_byte;
                  m_axis_tvalid <= 1'b1;
               end else if (m_axis_tready) begin
                  m_axis_tvalid <= 1'b0;
                  tx_idx        <= tx_idx + 2'd1;
                  if (tx_idx == 2'd3) begin
                     s_axis_tready <= 1'b1;
                     state         <= HDR_OP;
                  end
               end
            end
            ECHO: begin
               // ready only with the buffer empty, so rx and tx never fire together
               if (rx_fire) begin
                  m_axis_tdata  <= s_axis_tdata;
                  m_axis_tvalid <= 1'b1;
                  rx_cnt        <= rx_cnt - LEN_W'(1);
                  s_axis_tready <= 1'b0;
               end else if (tx_fire) begin
                  m_axis_tvalid <= 1'b0;
                  tx_cnt        <= tx_cnt - LEN_W'(1);
                  if (tx_cnt == LEN_W'(1)) begin
                     s_axis_tready <= 1'b1;
                     state         <= HDR_OP;
                  end else begin
                     s_axis_tready <= (rx_cnt != '0);
                  end
               end
            end
            DRAIN_HDR, DRAIN: if (rx_fire) begin
               rx_cnt <= rx_cnt - LEN_W'(1);
               if (rx_cnt == LEN_W'(1)) state <= HDR_OP;
            end
            default: begin
               s_axis_tready <= 1'b1;
               state         <= HDR_OP;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_packet_ctrl.sv
// Randomised bench for alu_packet_ctrl: a packet-level model predicts tx bytes,
// ALU start operands and error pulses; a per-cycle monitor compares the DUT against it.
module tb_alu_packet_ctrl;
   localparam logic [7:0] ECHO_OP = 8'hEC;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic [7:0]  alu_op_o;
   logic [31:0] alu_a_o;
   logic [31:0] alu_b_o;
   logic        alu_start_o;
   logic        alu_done_i;
   logic [31:0] alu_result_i;
   logic        busy_o;
   logic        err_o;

   alu_packet_ctrl #(.ECHO_OP(ECHO_OP), .LEN_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_start_o(alu_start_o),
      .alu_done_i(alu_done_i), .alu_result_i(alu_result_i),
      .busy_o(busy_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  pkt_q[$];
   logic [7:0]  exp_tx[$];
   logic [71:0] exp_start[$];
   int          exp_err = 0;
   bit          stall = 1'b0;
   bit          no_wait_chk = 1'b0;
   bit          pending = 1'b0;
   bit          sending = 1'b0;
   int          force_delay = -1;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=unexpected-event required=none", name);
   endtask

   task automatic abort(input string name);
      errors++;
      $display("FAIL %s actual=timeout required=progress", name);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "bench aborted");
   endtask

   function automatic logic [31:0] bench_alu(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         8'hAD:   return a + b;
         8'h5B:   return a - b;
         default: return (a ^ b) + {24'h0, op};
      endcase
   endfunction

   // Packet-level reference: what the controller must emit for the bytes in pkt_q
   task automatic model_pkt();
      logic [7:0]  op;
      logic [15:0] len;
      int          p;
      logic [31:0] acc, w;
      op  = pkt_q[0];
      len = {pkt_q[3], pkt_q[2]};
      if (pkt_q[1] != 8'h00 || len < 16'd4) begin
         exp_err++;
         return;
      end
      p = int'(len) - 4;
      if (op == ECHO_OP) begin
         for (int i = 0; i < p; i++) exp_tx.push_back(pkt_q[4+i]);
         return;
      end
      if (p < 4 || p % 4 != 0) begin
         exp_err++;
         return;
      end
      acc = {pkt_q[4], pkt_q[5], pkt_q[6], pkt_q[7]};
      for (int k = 1; k < p / 4; k++) begin
         w = {pkt_q[4+4*k], pkt_q[5+4*k], pkt_q[6+4*k], pkt_q[7+4*k]};
         exp_start.push_back({op, acc, w});
         acc = bench_alu(op, acc, w);
      end
      for (int i = 3; i >= 0; i--) exp_tx.push_back(acc[8*i +: 8]);
   endtask

   task automatic add_hdr(input logic [7:0] op, input logic [7:0] rsv, input logic [15:0] len);
      pkt_q.push_back(op);
      pkt_q.push_back(rsv);
      pkt_q.push_back(len[7:0]);
      pkt_q.push_back(len[15:8]);
   endtask

   task automatic add_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) pkt_q.push_back(w[8*i +: 8]);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t;
      t = 0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = b;
      @(negedge clk);
      while (!s_axis_tready) begin
         t++;
         if (t > 500) abort("rx_stuck");
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 8'($urandom);
      repeat ($urandom_range(0, 1)) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_pkt();
      sending = 1'b1;
      foreach (pkt_q[i]) send_byte(pkt_q[i]);
      sending = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((exp_tx.size() != 0 || exp_start.size() != 0 || exp_err != 0 ||
              busy_o || pending || sending) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("idle_tx_left", exp_tx.size(), 0);
      chk("idle_start_left", exp_start.size(), 0);
      chk("idle_err_left", exp_err, 0);
      chk("idle_busy", busy_o, 0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares every handshake / pulse against the model queues
   logic       prev_v = 1'b0, prev_r = 1'b0, prev_start = 1'b0;
   logic [7:0] prev_d = '0;
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (prev_v && !prev_r)
            chk("tx_hold", {m_axis_tvalid, m_axis_tdata}, {1'b1, prev_d});
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_tx.size() == 0) fail("tx_extra");
            else chk("tx_byte", m_axis_tdata, exp_tx.pop_front());
         end
         if (alu_start_o) begin
            if (prev_start) fail("start_width");
            if (exp_start.size() == 0) fail("start_extra");
            else chk("alu_start", {alu_op_o, alu_a_o, alu_b_o}, exp_start.pop_front());
         end
         if (err_o) begin
            if (exp_err == 0) fail("err_extra");
            else exp_err--;
         end
         if (pending && !no_wait_chk && s_axis_tready) fail("rdy_in_wait");
      end
      prev_v     = m_axis_tvalid;
      prev_r     = m_axis_tready;
      prev_d     = m_axis_tdata;
      prev_start = alu_start_o;
   end

   // Bench ALU: answers each start after a random latency
   initial begin
      logic [31:0] ra, rb;
      logic [7:0]  rop;
      int          d;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && alu_start_o === 1'b1) begin
            ra = alu_a_o; rb = alu_b_o; rop = alu_op_o;
            pending = 1'b1;
            d = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 4));
            repeat (d + 1) @(posedge clk);
            #1;
            alu_done_i   = 1'b1;
            alu_result_i = bench_alu(rop, ra, rb);
            pending      = 1'b0;
            @(posedge clk);
            #1;
            alu_done_i   = 1'b0;
            alu_result_i = $urandom;
         end
      end
   end

   // tx sink with random backpressure
   initial begin
      forever begin
         @(posedge clk);
         #1;
         m_axis_tready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   task automatic random_pkt();
      int          kind, n;
      logic [7:0]  op;
      pkt_q.delete();
      kind = $urandom_range(0, 9);
      op   = 8'($urandom);
      if (kind <= 4) begin
         if (op == ECHO_OP) op = 8'hAD;
         if (kind == 0) op = 8'hAD;
         if (kind == 1) op = 8'h5B;
         n = $urandom_range(1, 4);
         add_hdr(op, 8'h00, 16'(4 + 4 * n));
         for (int i = 0; i < n; i++) add_word($urandom);
      end else if (kind <= 6) begin
         n = $urandom_range(0, 6);
         add_hdr(ECHO_OP, 8'h00, 16'(4 + n));
         for (int i = 0; i < n; i++) pkt_q.push_back(8'($urandom));
      end else if (kind == 7) begin
         add_hdr(op, 8'($urandom_range(1, 255)), 16'($urandom));
      end else if (kind == 8) begin
         add_hdr(op, 8'h00, 16'($urandom_range(0, 3)));
      end else begin
         if (op == ECHO_OP) op = 8'h11;
         n = $urandom_range(0, 9);
         if (n % 4 == 0 && n != 0) n++;
         add_hdr(op, 8'h00, 16'(4 + n));
         for (int i = 0; i < n; i++) pkt_q.push_back(8'($urandom));
      end
   endtask

   initial begin
      int t;
      rst_n = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
      m_axis_tready = 1'b0; alu_done_i = 1'b0; alu_result_i = '0;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_outs", {m_axis_tvalid, m_axis_tdata, alu_start_o, alu_op_o, alu_a_o, alu_b_o, busy_o, err_o}, 0);
      chk("rst_tready", s_axis_tready, 1);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // two-word add
      pkt_q.delete(); add_hdr(8'hAD, 8'h00, 16'h000C); add_word(32'd5); add_word(32'd7);
      model_pkt();
      chk("pin_add_tx", {exp_tx[0], exp_tx[1], exp_tx[2], exp_tx[3]}, 32'h0000000C);
      chk("pin_add_start", exp_start[0], {8'hAD, 32'd5, 32'd7});
      send_pkt(); wait_idle();

      // three-word fold
      pkt_q.delete(); add_hdr(8'hAD, 8'h00, 16'h0010); add_word(32'd1); add_word(32'd2); add_word(32'd3);
      model_pkt();
      chk("pin_fold_tx", {exp_tx[0], exp_tx[1], exp_tx[2], exp_tx[3]}, 32'h00000006);
      chk("pin_fold_starts", {exp_start[0], exp_start[1]}, {8'hAD, 32'd1, 32'd2, 8'hAD, 32'd3, 32'd3});
      send_pkt(); wait_idle();

      // single word passes straight through
      pkt_q.delete(); add_hdr(8'h88, 8'h00, 16'h0008); add_word(32'hDEADBEEF);
      model_pkt();
      chk("pin_single_tx", {exp_tx[0], exp_tx[1], exp_tx[2], exp_tx[3]}, 32'hDEADBEEF);
      chk("pin_single_nostart", exp_start.size(), 0);
      send_pkt(); wait_idle();

      // echo with tx stalled for 20 cycles
      pkt_q.delete(); add_hdr(ECHO_OP, 8'h00, 16'h0007);
      pkt_q.push_back(8'h41); pkt_q.push_back(8'h42); pkt_q.push_back(8'h43);
      model_pkt();
      chk("pin_echo_tx", {exp_tx.size(), exp_tx[0], exp_tx[1], exp_tx[2]}, {32'd3, 24'h414243});
      stall = 1'b1;
      sending = 1'b1;
      fork send_pkt(); join_none
      repeat (20) @(negedge clk);
      chk("echo_stall_rdy", s_axis_tready, 0);
      chk("echo_stall_hold", {m_axis_tvalid, m_axis_tdata}, {1'b1, 8'h41});
      @(posedge clk); #1 stall = 1'b0;
      wait_idle();

      // bad reserved byte, then short payload, then a good packet
      pkt_q.delete(); add_hdr(8'hAD, 8'h01, 16'h000C);
      model_pkt();
      chk("pin_rsv_err", exp_err, 1);
      send_pkt(); wait_idle();
      pkt_q.delete(); add_hdr(8'hAD, 8'h00, 16'h0006); pkt_q.push_back(8'h12); pkt_q.push_back(8'h34);
      model_pkt();
      chk("pin_short_err", {exp_err, exp_tx.size()}, {32'd1, 32'd0});
      send_pkt(); wait_idle();
      pkt_q.delete(); add_hdr(8'h5B, 8'h00, 16'h000C); add_word(32'd100); add_word(32'd1);
      model_pkt();
      chk("pin_sub_tx", {exp_tx[0], exp_tx[1], exp_tx[2], exp_tx[3]}, 32'd99);
      send_pkt(); wait_idle();

      // reset while waiting on the ALU; its late done must be ignored
      pkt_q.delete(); add_hdr(8'hAD, 8'h00, 16'h000C); add_word(32'd10); add_word(32'd20);
      model_pkt();
      force_delay = 12;
      send_pkt();
      t = 0;
      while (!pending && t < 200) begin @(negedge clk); t++; end
      chk("rstw_reached_wait", pending, 1);
      @(posedge clk); #1;
      no_wait_chk = 1'b1;
      rst_n = 1'b0;
      exp_tx.delete(); exp_start.delete(); exp_err = 0;
      @(negedge clk);
      chk("rstw_outs", {m_axis_tvalid, m_axis_tdata, alu_start_o, alu_op_o, alu_a_o, alu_b_o, busy_o, err_o}, 0);
      chk("rstw_tready", s_axis_tready, 1);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      t = 0;
      while (pending && t < 200) begin @(negedge clk); t++; end
      repeat (3) @(negedge clk);
      chk("late_done_ignored", {busy_o, m_axis_tvalid}, 0);
      @(posedge clk); #1;
      no_wait_chk = 1'b0;
      force_delay = -1;
      pkt_q.delete(); add_hdr(8'hAD, 8'h00, 16'h000C); add_word(32'h11111111); add_word(32'h22222222);
      model_pkt();
      chk("pin_after_rst_tx", {exp_tx[0], exp_tx[1], exp_tx[2], exp_tx[3]}, 32'h33333333);
      send_pkt(); wait_idle();

      for (int i = 0; i < 40; i++) begin
         random_pkt();
         model_pkt();
         send_pkt();
         wait_idle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
